// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-stage program-counter generator. Holds the fetch PC and
//            picks the next PC by fixed priority:
//              rst > trap > PCSrc > RAS pop > stall > PC+4.
//            Every redirect target is forced to a 4-byte boundary, and
//            misaligned flags a winning target whose low bits were nonzero.
//            An optional return address stack (RAS) predicts returns.
// Macro    : PC_GEN_RAS_EN - when defined, the RAS storage and logic are
//            built. When undefined, the RAS ports are ignored and
//            ras_valid/ras_top are tied to 0. The port list is the same
//            in both builds.
// Params   : XLEN         - PC width in bits (>= 8)
//            RESET_VECTOR - PC loaded on reset (4-byte aligned)
//            RAS_DEPTH    - RAS entries (power of two, 2..16)
// Ports    : clk, rst (synchronous, active high)
//            stall, PCSrc/PCTarget, trap/trap_vec  - next-PC controls
//            ras_push/ras_push_addr, ras_pop        - RAS controls
//            PC, PCPlus4                            - fetch PC and PC+4
//            misaligned                             - redirect target flag
//            ras_valid, ras_top                     - RAS status
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            misaligned,
    output logic            ras_valid,
    output logic [XLEN-1:0] ras_top
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    // A RAS pop only redirects when the stack holds an entry and no
    // higher-priority redirect is present. The same qualified pop also
    // drives the stack update, so a suppressed pop leaves the stack alone.
    logic            w_ras_take;

    assign w_pc_plus4 = r_pc + XLEN'(4);

`ifdef PC_GEN_RAS_EN
    localparam int                 c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(RAS_DEPTH);

    // Circular buffer. r_ptr addresses the top entry; r_cnt is the number of
    // valid entries. Once full, a push lands on the oldest entry, which is
    // exactly the slot after the top.
    logic [XLEN-1:0]    r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w:0]   r_cnt;

    assign ras_valid  = (r_cnt != '0);
    assign ras_top    = ras_valid ? r_stack[r_ptr] : '0;
    assign w_ras_take = ras_pop && ras_valid && !trap && !PCSrc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (ras_push && w_ras_take) begin
            // Pop and push together: the return consumes the top entry and
            // the new call replaces it, so the depth does not change.
            r_stack[r_ptr] <= ras_push_addr;
        end else if (ras_push) begin
            r_stack[r_ptr + c_ptr_w'(1)] <= ras_push_addr;
            r_ptr                        <= r_ptr + c_ptr_w'(1);
            if (r_cnt != c_depth) begin
                r_cnt <= r_cnt + (c_ptr_w + 1)'(1);
            end
        end else if (w_ras_take) begin
            r_ptr <= r_ptr - c_ptr_w'(1);
            r_cnt <= r_cnt - (c_ptr_w + 1)'(1);
        end
    end
`else
    localparam int c_unused_depth = RAS_DEPTH;
    logic          w_unused_ras;

    assign w_unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign ras_valid    = 1'b0;
    assign ras_top      = '0;
    assign w_ras_take   = 1'b0;
`endif

    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        w_pc_next  = w_pc_plus4;
        if (trap) begin
            w_redirect = 1'b1;
            w_target   = trap_vec;
        end else if (PCSrc) begin
            w_redirect = 1'b1;
            w_target   = PCTarget;
        end else if (w_ras_take) begin
            w_redirect = 1'b1;
            w_target   = ras_top;
        end
        // A redirect overrides stall; the low two bits are dropped.
        if (w_redirect) begin
            w_pc_next = {w_target[XLEN-1:2], 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    assign misaligned = w_redirect && (w_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign PC      = r_pc;
    assign PCPlus4 = w_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen. Directed vector table, RAS
//            corner sequences, randomized traffic against a queue-based
//            reference model, and an XLEN = 16 wrap-around instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] c_rv    = 32'h100;
    localparam int          c_depth = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit          c_ras_en = 1'b1;
`else
    localparam bit          c_ras_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, PCSrc, trap, ras_push, ras_pop;
    logic [31:0] PCTarget, trap_vec, ras_push_addr;
    logic [31:0] PC, PCPlus4, ras_top;
    logic        misaligned, ras_valid;

    logic        rst16 = 1'b1;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0;
    logic [15:0] pc16, pc16_plus4, ras_top16;
    logic        mis16, ras_valid16;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch PC plus the RAS as a queue (newest at the back).
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(c_rv), .RAS_DEPTH(c_depth)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .trap(trap), .trap_vec(trap_vec), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .PC(PC),
        .PCPlus4(PCPlus4), .misaligned(misaligned), .ras_valid(ras_valid),
        .ras_top(ras_top)
    );

    pc_gen #(.XLEN(16), .RESET_VECTOR(16'hFFF0), .RAS_DEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst16), .stall(zero1), .PCSrc(zero1), .PCTarget(zero16),
        .trap(zero1), .trap_vec(zero16), .ras_push(zero1),
        .ras_push_addr(zero16), .ras_pop(zero1), .PC(pc16),
        .PCPlus4(pc16_plus4), .misaligned(mis16), .ras_valid(ras_valid16),
        .ras_top(ras_top16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check misaligned before the edge, advance
    // the model, then compare registered state after the edge.
    task automatic step(input logic a_rst, input logic a_stall, input logic a_pcsrc,
                        input logic [31:0] a_tgt, input logic a_trap,
                        input logic [31:0] a_tvec, input logic a_push,
                        input logic [31:0] a_paddr, input logic a_pop,
                        output logic o_mis);
        logic        take;
        logic        exp_mis;
        logic [31:0] exp_top;
        rst = a_rst; stall = a_stall; PCSrc = a_pcsrc; PCTarget = a_tgt;
        trap = a_trap; trap_vec = a_tvec; ras_push = a_push;
        ras_push_addr = a_paddr; ras_pop = a_pop;
        #1;
        o_mis   = misaligned;
        take    = c_ras_en && a_pop && (m_ras.size() > 0) && !a_trap && !a_pcsrc;
        exp_mis = 1'b0;
        if (a_trap)       exp_mis = (a_tvec[1:0] != 2'b00);
        else if (a_pcsrc) exp_mis = (a_tgt[1:0] != 2'b00);
        else if (take)    exp_mis = (m_ras[m_ras.size()-1][1:0] != 2'b00);
        if (!a_rst) check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});

        if (a_rst) begin
            m_pc = c_rv;
            m_ras.delete();
        end else begin
            if (a_trap)       m_pc = a_tvec & ~32'h3;
            else if (a_pcsrc) m_pc = a_tgt & ~32'h3;
            else if (take)    m_pc = m_ras[m_ras.size()-1] & ~32'h3;
            else if (!a_stall) m_pc = m_pc + 32'd4;
            if (c_ras_en) begin
                if (a_push && take) begin
                    m_ras[m_ras.size()-1] = a_paddr;
                end else if (a_push) begin
                    m_ras.push_back(a_paddr);
                    if (m_ras.size() > c_depth) void'(m_ras.pop_front());
                end else if (take) begin
                    void'(m_ras.pop_back());
                end
            end
        end

        @(posedge clk);
        #1;
        exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
        check("pc", PC, m_pc);
        check("pcplus4", PCPlus4, m_pc + 32'd4);
        check("ras_valid", {31'b0, ras_valid}, {31'b0, (m_ras.size() > 0)});
        check("ras_top", ras_top, exp_top);
    endtask

    // Shorthands for RAS-only and idle cycles.
    task automatic ras_step(input logic a_push, input logic [31:0] a_paddr, input logic a_pop);
        logic m;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a_push, a_paddr, a_pop, m);
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic        trap;
        logic [31:0] tvec;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic        mis_seen;
        logic [31:0] pc_before;

        //             rst   stall pcsrc target        trap  tvec          exp_pc        mis
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h108,      1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h10C,      1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 32'h0,        32'h8,        1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        32'h40,       1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h40,       1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h42,       1'b1, 32'h200,      32'h200,      1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h42,       1'b0, 32'h0,        32'h40,       1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h203,      32'h200,      1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h200,      1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h41,       1'b0, 32'h0,        32'h40,       1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h44,       1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        32'h100,      1'b0};

        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].pcsrc, vecs[i].target, vecs[i].trap,
                 vecs[i].tvec, 1'b0, 32'h0, 1'b0, mis_seen);
            check($sformatf("tbl%0d_pc", i), PC, vecs[i].exp_pc);
            check($sformatf("tbl%0d_pcplus4", i), PCPlus4, vecs[i].exp_pc + 32'd4);
            check($sformatf("tbl%0d_mis", i), {31'b0, mis_seen}, {31'b0, vecs[i].exp_mis});
        end
        check("reset_ras_valid", {31'b0, ras_valid}, 32'h0);
        check("reset_ras_top", ras_top, 32'h0);

        // RAS sequence: five pushes into a four-deep stack, then pops.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, mis_seen);
        for (int i = 1; i <= 5; i++) ras_step(1'b1, 32'(i * 16), 1'b0);
`ifdef PC_GEN_RAS_EN
        check("ras_full_top", ras_top, 32'h50);
        check("ras_full_valid", {31'b0, ras_valid}, 32'h1);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pop1_pc", PC, 32'h50);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pop2_pc", PC, 32'h40);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pop3_pc", PC, 32'h30);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pop4_pc", PC, 32'h20);
        check("pop4_valid", {31'b0, ras_valid}, 32'h0);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pop_empty_pc", PC, 32'h24);
        ras_step(1'b1, 32'h10, 1'b0);
        ras_step(1'b1, 32'h20, 1'b0);
        ras_step(1'b1, 32'h99, 1'b1);
        check("pushpop_pc", PC, 32'h20);
        check("pushpop_top", ras_top, 32'h99);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pushpop_next_pc", PC, 32'h98);
        ras_step(1'b0, 32'h0, 1'b1);
        check("pushpop_depth_pc", PC, 32'h10);
        check("pushpop_depth_valid", {31'b0, ras_valid}, 32'h0);
        ras_step(1'b1, 32'h77, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h99, 1'b1, mis_seen);
        check("rst_pushpop_pc", PC, c_rv);
        check("rst_pushpop_valid", {31'b0, ras_valid}, 32'h0);
`else
        check("noras_valid", {31'b0, ras_valid}, 32'h0);
        check("noras_top", ras_top, 32'h0);
        pc_before = PC;
        ras_step(1'b0, 32'h0, 1'b1);
        check("noras_pop_pc", PC, pc_before + 32'd4);
        check("noras_pop_valid", {31'b0, ras_valid}, 32'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 15) == 0),
                 $urandom, ($urandom_range(0, 3) == 0), $urandom,
                 ($urandom_range(0, 2) == 0), mis_seen);
        end

        // XLEN = 16 instance: sequential wrap from 0xFFFC to 0x0000.
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        check("x16_reset_pc", {16'h0, pc16}, 32'hFFF0);
        rst16 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("x16_pc%0d", i), {16'h0, pc16}, (32'hFFF0 + 32'(i * 4)) & 32'hFFFF);
            if (i == 3) check("x16_pcplus4_wrap", {16'h0, pc16_plus4}, 32'h0);
        end
        check("x16_ras_valid", {31'b0, ras_valid16}, 32'h0);
        check("x16_mis", {31'b0, mis16}, 32'h0);
        check("x16_ras_top", {16'h0, ras_top16}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
